sp_operand_loader: RTL and testbench

//   Streaming front-end for the combinational scalar_product block. Collects one
//   (a,b) element pair per handshake and packs Ndata pairs into the A/B operand buses.

---
 rtl/sp_operand_loader.sv | 91 +++++++++
 tb/tb_sp_operand_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sp_operand_loader.sv
// sp_operand_loader: serial (a,b) element collector that packs Ndata pairs
// into the A/B operand buses of scalar_product, holds them for SETTLE_CYC
// cycles, then captures scalar_product.out onto a valid/ready result port.
module sp_operand_loader #(
  parameter int Nbits      = 4,
  parameter int Ndata      = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [Nbits-1:0]       in_a,
  input  logic [Nbits-1:0]       in_b,
  output logic [Ndata*Nbits-1:0] A,
  output logic [Ndata*Nbits-1:0] B,
  input  logic [2*Nbits-1:0]     sp_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [2*Nbits-1:0]     res_data,
  output logic                   busy
);

  // Counter widths stay at least one bit so Ndata=1 / SETTLE_CYC=1 elaborate.
  localparam int EW = (Ndata > 1) ? $clog2(Ndata) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [EW-1:0] ELEM_LAST   = EW'(Ndata - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    RESULT
  } state_t;

  state_t          state;
  logic [EW-1:0]   elem_cnt;
  logic [SW-1:0]   settle_cnt;
  logic            accept;

  // Ready only in LOAD and never while reset is asserted.
  assign in_ready = (state == LOAD) && !rst;
  assign busy     = (state != LOAD);
  assign accept   = in_valid && in_ready;

  // Loader FSM: collect elements, hold operands while settling, present result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      elem_cnt   <= '0;
      settle_cnt <= '0;
      A          <= '0;
      B          <= '0;
      res_data   <= '0;
      res_valid  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            A[int'(elem_cnt)*Nbits +: Nbits] <= in_a;
            B[int'(elem_cnt)*Nbits +: Nbits] <= in_b;
            if (elem_cnt == ELEM_LAST) begin
              elem_cnt   <= '0;
              settle_cnt <= '0;
              state      <= SETTLE;
            end else begin
              elem_cnt <= elem_cnt + 1'b1;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            res_data  <= sp_out;
            res_valid <= 1'b1;
            state     <= RESULT;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_operand_loader.sv
// Self-checking bench for sp_operand_loader with a behavioural scalar_product
// attached; expected results are queued as vectors are sent and popped when
// the loader presents a result.
module tb_sp_operand_loader;

  localparam int NB = 4;
  localparam int ND = 4;
  localparam int SC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic [15:0] A;
  logic [15:0] B;
  logic [7:0]  sp_out;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] mA;
  logic [15:0] mB;
  int          mk;

  sp_operand_loader #(.Nbits(NB), .Ndata(ND), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .A(A), .B(B), .sp_out(sp_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural scalar_product: sum of element products modulo 256.
  always_comb begin
    sp_out = '0;
    for (int i = 0; i < ND; i++)
      sp_out = sp_out + ({4'b0, A[i*NB +: NB]} * {4'b0, B[i*NB +: NB]});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mA = '0; mB = '0; mk = 0;
  endtask

  // Offer one pair, wait (bounded) for acceptance, then optional idle cycles.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input int idle);
    int t;
    in_a = a; in_b = b; in_valid = 1'b1; t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send_timeout", {15'b0, in_ready}, 16'd1);
    @(negedge clk);
    mA[mk*NB +: NB] = a;
    mB[mk*NB +: NB] = b;
    mk = (mk == ND - 1) ? 0 : mk + 1;
    check("A_after_accept", A, mA);
    check("B_after_accept", B, mB);
    if (idle > 0) begin
      in_valid = 1'b0;
      for (int i = 0; i < idle; i++) begin
        @(negedge clk);
        check("A_idle_hold", A, mA);
        check("B_idle_hold", B, mB);
      end
    end
  endtask

  task automatic send_vec(input logic [15:0] av, input logic [15:0] bv,
                          input logic [7:0] exp, input bit gaps);
    exp_q.push_back(exp);
    for (int i = 0; i < ND; i++)
      send(av[i*NB +: NB], bv[i*NB +: NB],
           (gaps && i < ND - 1) ? int'($urandom_range(1, 3)) : 0);
    check("A_packed", A, av);
    check("B_packed", B, bv);
    check("in_ready_settle", {15'b0, in_ready}, 16'd0);
    check("busy_settle", {15'b0, busy}, 16'd1);
  endtask

  // Wait for res_valid; latency counted from the negedge after the last accept.
  task automatic wait_res(input bit check_lat);
    int n;
    logic [7:0] e;
    n = 0;
    while (res_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("res_valid_timeout", {15'b0, res_valid}, 16'd1);
    if (check_lat) check("result_latency", 16'(n), 16'(SC));
    if (exp_q.size() == 0) begin
      check("unexpected_result", {15'b0, res_valid}, 16'd0);
    end else begin
      e = exp_q.pop_front();
      check("res_data", {8'b0, res_data}, {8'b0, e});
    end
  endtask

  task automatic consume(input bit tied);
    in_valid  = 1'b0;
    res_ready = 1'b1;
    check("in_ready_in_result", {15'b0, in_ready}, 16'd0);
    @(negedge clk);
    if (!tied) res_ready = 1'b0;
    check("res_valid_cleared", {15'b0, res_valid}, 16'd0);
    check("in_ready_after_hs", {15'b0, in_ready}, 16'd1);
    check("busy_after_hs", {15'b0, busy}, 16'd0);
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("in_ready_in_rst", {15'b0, in_ready}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_A", A, 16'h0000);
    check("rst_B", B, 16'h0000);
    check("rst_res_valid", {15'b0, res_valid}, 16'd0);
    check("rst_res_data", {8'b0, res_data}, 16'h0000);
    check("rst_in_ready", {15'b0, in_ready}, 16'd1);
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; in_a = '0; in_b = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("in_ready_held_rst", {15'b0, in_ready}, 16'd0);
    pulse_reset();

    // 1 + 4: held valid, then result held off for 10 cycles with valid high
    send_vec(16'h4321, 16'h8765, 8'h46, 1'b0);
    wait_res(1'b1);
    in_a = 4'h9; in_b = 4'h9; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_res_valid", {15'b0, res_valid}, 16'd1);
      check("hold_res_data", {8'b0, res_data}, 16'h0046);
      check("hold_in_ready", {15'b0, in_ready}, 16'd0);
      check("hold_A", A, mA);
      check("hold_B", B, mB);
    end
    consume(1'b0);

    // 2: all-ones wrap
    send_vec(16'hFFFF, 16'hFFFF, 8'h84, 1'b0);
    wait_res(1'b1);
    consume(1'b0);

    // 3: idle gaps between pairs
    send_vec(16'h4321, 16'h8765, 8'h46, 1'b1);
    wait_res(1'b1);
    consume(1'b0);

    // 5: reset after two pairs, then a fresh vector
    send(4'h2, 4'h3, 0);
    send(4'h4, 4'h5, 0);
    pulse_reset();
    send_vec(16'h1111, 16'h1111, 8'h04, 1'b0);
    wait_res(1'b1);
    consume(1'b0);

    // reset while a result is pending drops it
    send_vec(16'h2222, 16'h3333, 8'h18, 1'b0);
    wait_res(1'b1);
    pulse_reset();

    // 6: res_ready tied high, back-to-back vectors
    res_ready = 1'b1;
    send_vec(16'h4321, 16'h8765, 8'h46, 1'b0);
    wait_res(1'b1);
    consume(1'b1);
    send_vec(16'hFFFF, 16'hFFFF, 8'h84, 1'b0);
    wait_res(1'b1);
    consume(1'b1);
    res_ready = 1'b0;

    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
